// File: rtl/uart0_pkg.sv
// Shared constants for the uart0 TX controller: register offsets,
// STATUS/CTRL bit positions and the sequencer state encoding.
package uart0_pkg;

    // Register word offsets inside the uart0 window
    localparam logic [1:0] UART0_DATA   = 2'd0;
    localparam logic [1:0] UART0_STATUS = 2'd1;
    localparam logic [1:0] UART0_CTRL   = 2'd2;

    // STATUS bit positions; level occupies [FIFO_AW+4:4]
    localparam int STAT_FULL      = 0;
    localparam int STAT_EMPTY     = 1;
    localparam int STAT_BUSY      = 2;
    localparam int STAT_OVF       = 3;
    localparam int STAT_LEVEL_LSB = 4;

    // CTRL bit positions
    localparam int CTRL_EN    = 0;
    localparam int CTRL_IEN   = 1;
    localparam int CTRL_FLUSH = 2;

    // Sequencer states (binary encoded)
    typedef logic [1:0] state_t;
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_ARM   = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

endpackage

// File: rtl/uart0_tx_ctrl_fifo.sv
// Synchronous FIFO with first-word-fall-through head output.
// flush and reset both empty the FIFO; flush wins over a push in the same cycle.
// A push while full is accepted only when a pop frees a slot in the same cycle.
module sync_fifo #(
    parameter int DW = 8,
    parameter int AW = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    input  logic          flush,
    output logic [DW-1:0] head,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   level
);

    localparam logic [AW:0] DEPTH = (AW+1)'(2**AW);

    logic [DW-1:0] mem [2**AW];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   cnt;
    logic          do_push;
    logic          do_pop;

    assign empty   = (cnt == '0);
    assign full    = (cnt == DEPTH);
    assign level   = cnt;
    assign head    = mem[rd_ptr];
    assign do_pop  = pop & ~empty;
    assign do_push = push & ~flush & (~full | do_pop);

    // Pointer and occupancy update; flush behaves like a local reset
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + (AW+1)'(1);
                2'b01:   cnt <= cnt - (AW+1)'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Storage array; contents need no reset because cnt gates visibility
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/uart0_tx_ctrl.sv
// Bus-facing sequencer for the uart0_tx serializer: register window,
// TX FIFO, and a LOAD/ARM/DRAIN sequencer that feeds one byte per frame.
module uart0_tx_ctrl
    import uart0_pkg::*;
#(
    parameter int FIFO_AW = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        bus_sel,
    input  logic [1:0]  bus_addr,
    input  logic        bus_wr_en,
    input  logic [31:0] bus_wr_data,
    output logic [31:0] bus_rd_data,
    output logic        uart_wr_en,
    output logic [31:0] uart_wr_data,
    input  logic        uart_wr_empty,
    output logic        irq,
    output logic [1:0]  fsm_state
);

    // Handshake with uart0_tx: uart_wr_en is a single-cycle load strobe
    // carrying uart_wr_data; the serializer has no ready, so a new load is
    // only issued once uart_wr_empty=1 is seen in IDLE, and uart_wr_empty
    // is not trusted again until the cycle after ARM (it is stale before).

    state_t             state;
    state_t             state_nxt;
    logic               en;
    logic               ien;
    logic               ovf;
    logic [7:0]         tx_byte;

    logic               wr_sel;
    logic               data_wr;
    logic               status_wr;
    logic               ctrl_wr;
    logic               flush_req;
    logic               pop;
    logic               ovf_set;
    logic               ovf_clr;

    logic [7:0]         fifo_head;
    logic               fifo_full;
    logic               fifo_empty;
    logic [FIFO_AW:0]   fifo_level;
    logic               unused_wr_bits;

    assign wr_sel    = bus_sel & bus_wr_en;
    assign data_wr   = wr_sel & (bus_addr == UART0_DATA);
    assign status_wr = wr_sel & (bus_addr == UART0_STATUS);
    assign ctrl_wr   = wr_sel & (bus_addr == UART0_CTRL);
    assign flush_req = ctrl_wr & bus_wr_data[CTRL_FLUSH];
    assign pop       = (state == S_LOAD);

    // A byte is lost for lack of room only if no pop frees a slot; a byte
    // dropped because of a simultaneous flush does not count as overflow.
    assign ovf_set   = data_wr & fifo_full & ~pop & ~flush_req;
    assign ovf_clr   = status_wr & bus_wr_data[STAT_OVF];

    assign unused_wr_bits = ^bus_wr_data[31:8];

    sync_fifo #(
        .DW (8),
        .AW (FIFO_AW)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (data_wr),
        .push_data (bus_wr_data[7:0]),
        .pop       (pop),
        .flush     (flush_req),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    // Sticky overflow flag; a set in the same cycle beats a clear
    always_ff @(posedge clk) begin
        if (!rst_n)       ovf <= 1'b0;
        else if (ovf_set) ovf <= 1'b1;
        else if (ovf_clr) ovf <= 1'b0;
    end

    // CTRL enable bits; flush is a pulse and is not stored
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            en  <= 1'b0;
            ien <= 1'b0;
        end else if (ctrl_wr) begin
            en  <= bus_wr_data[CTRL_EN];
            ien <= bus_wr_data[CTRL_IEN];
        end
    end

    // Next-state logic; a flush in the decision cycle suppresses the load
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (en && !fifo_empty && uart_wr_empty && !flush_req)
                         state_nxt = S_LOAD;
            S_LOAD:  state_nxt = S_ARM;
            S_ARM:   state_nxt = S_DRAIN;
            S_DRAIN: if (uart_wr_empty) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Capture the FIFO head on entry to LOAD so the byte is stable during the strobe
    always_ff @(posedge clk) begin
        if (!rst_n)
            tx_byte <= 8'h00;
        else if (state == S_IDLE && state_nxt == S_LOAD)
            tx_byte <= fifo_head;
    end

    assign uart_wr_en   = (state == S_LOAD);
    assign uart_wr_data = {24'b0, tx_byte};
    assign irq          = ien & fifo_empty & (state == S_IDLE);
    assign fsm_state    = state;

    // Combinational register read mux
    always_comb begin
        bus_rd_data = '0;
        if (bus_sel) begin
            case (bus_addr)
                UART0_STATUS: begin
                    bus_rd_data[STAT_FULL]  = fifo_full;
                    bus_rd_data[STAT_EMPTY] = fifo_empty;
                    bus_rd_data[STAT_BUSY]  = (state != S_IDLE);
                    bus_rd_data[STAT_OVF]   = ovf;
                    bus_rd_data[STAT_LEVEL_LSB +: FIFO_AW+1] = fifo_level;
                end
                UART0_CTRL: begin
                    bus_rd_data[CTRL_EN]  = en;
                    bus_rd_data[CTRL_IEN] = ien;
                end
                default: bus_rd_data = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_uart0_tx_ctrl.sv
// Bench for uart0_tx_ctrl: directed scenarios plus a randomized phase,
// a queue-based reference of the TX FIFO and a load monitor.
module tb_uart0_tx_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        bus_sel = 1'b0;
    logic [1:0]  bus_addr = 2'd0;
    logic        bus_wr_en = 1'b0;
    logic [31:0] bus_wr_data = 32'h0;
    logic [31:0] bus_rd_data;
    logic        uart_wr_en;
    logic [31:0] uart_wr_data;
    logic        uart_wr_empty;
    logic        irq;
    logic [1:0]  dbg_state;

    localparam logic [1:0] A_DATA = 2'd0, A_STATUS = 2'd1, A_CTRL = 2'd2, A_RSVD = 2'd3;
    localparam int DEPTH = 8;

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    uart0_tx_ctrl #(.FIFO_AW(3)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .bus_sel       (bus_sel),
        .bus_addr      (bus_addr),
        .bus_wr_en     (bus_wr_en),
        .bus_wr_data   (bus_wr_data),
        .bus_rd_data   (bus_rd_data),
        .uart_wr_en    (uart_wr_en),
        .uart_wr_data  (uart_wr_data),
        .uart_wr_empty (uart_wr_empty),
        .irq           (irq),
        .fsm_state     (dbg_state)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- uart0_tx model ----------------
    // After a load strobe the empty flag drops for frame_len cycles, then rises.
    int   frame_len = 10;
    int   ucnt = 0;
    logic u_empty = 1'b1;
    logic hold_low = 1'b0;
    assign uart_wr_empty = u_empty & ~hold_low;

    always @(posedge clk) begin
        if (uart_wr_en) begin
            ucnt    <= frame_len;
            u_empty <= 1'b0;
        end else if (ucnt > 0) begin
            if (ucnt == 1) u_empty <= 1'b1;
            ucnt <= ucnt - 1;
        end
    end

    // ---------------- reference model / scoreboard ----------------
    logic [7:0] exp_q[$];
    logic       ovf_m = 1'b0;
    int         checks = 0;
    int         errors = 0;
    int         load_count = 0;
    int         load_cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every load strobe must carry the oldest byte still owed
    always @(negedge clk) begin
        if (uart_wr_en) begin
            load_count = load_count + 1;
            load_cyc   = cyc;
            checks     = checks + 1;
            if (exp_q.size() == 0) begin
                errors = errors + 1;
                $display("FAIL load_unexpected: got data 0x%08h, no byte expected (cycle %0d)",
                         uart_wr_data, cyc);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (uart_wr_data !== {24'b0, e}) begin
                    errors = errors + 1;
                    $display("FAIL load_data: got 0x%08h expected 0x%08h (cycle %0d)",
                             uart_wr_data, {24'b0, e}, cyc);
                end
            end
        end
    end

    function automatic logic [31:0] status_word(input logic full, input logic empty,
                                                input logic busy, input logic ovf,
                                                input int level);
        logic [31:0] w;
        w = 32'(level) << 4;
        w[0] = full;
        w[1] = empty;
        w[2] = busy;
        w[3] = ovf;
        return w;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        exp_q.delete();
        ovf_m = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick(2);
        model_reset();
        rst_n = 1'b1;
        tick(1);
    endtask

    // One-cycle bus write; the reference model applies the same rules
    task automatic bus_write(input logic sel, input logic [1:0] addr, input logic [31:0] data);
        bus_sel     = sel;
        bus_addr    = addr;
        bus_wr_en   = 1'b1;
        bus_wr_data = data;
        if (sel) begin
            if (addr == A_DATA) begin
                // a load in this same cycle frees one slot
                if (exp_q.size() < DEPTH || uart_wr_en) exp_q.push_back(data[7:0]);
                else ovf_m = 1'b1;
            end else if (addr == A_STATUS) begin
                if (data[3]) ovf_m = 1'b0;
            end else if (addr == A_CTRL) begin
                if (data[2]) begin
                    if (uart_wr_en && exp_q.size() > 0) begin
                        logic [7:0] keep;
                        keep = exp_q[0];
                        exp_q.delete();
                        exp_q.push_back(keep);
                    end else begin
                        exp_q.delete();
                    end
                end
            end
        end
        tick(1);
        bus_sel   = 1'b0;
        bus_wr_en = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] addr, output logic [31:0] data);
        bus_sel  = 1'b1;
        bus_addr = addr;
        @(negedge clk);
        data = bus_rd_data;
        tick(1);
        bus_sel = 1'b0;
    endtask

    task automatic wait_load(input int budget, input string name);
        int start;
        bit seen;
        start = load_count;
        seen  = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick(1);
            if (load_count != start) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL %s: no load strobe within %0d cycles", name, budget);
        end
    endtask

    task automatic wait_uart_idle(input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (uart_wr_empty === 1'b1) begin
                seen = 1'b1;
                break;
            end
            tick(1);
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL uart_idle_timeout: uart_wr_empty still low after %0d cycles", budget);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] rd;
        int          w;
        int          start;
        int          prev_load;
        int          r;

        tick(1);
        do_reset();

        // 1. reset state and ignored writes
        bus_read(A_STATUS, rd);
        check("reset_status", rd, 32'h2);
        bus_read(A_CTRL, rd);
        check("reset_ctrl", rd, 32'h0);
        check("reset_uart_data", uart_wr_data, 32'h0);
        start = load_count;
        tick(100);
        check("reset_no_load", 32'(load_count - start), 32'h0);
        bus_write(1'b0, A_DATA, 32'hAA);
        bus_write(1'b1, A_RSVD, 32'hFF);
        bus_read(A_STATUS, rd);
        check("ignored_writes", rd, 32'h2);
        bus_read(A_CTRL, rd);
        check("ignored_ctrl", rd, 32'h0);

        // 2. single byte, latency and busy
        bus_write(1'b1, A_CTRL, 32'h1);
        w = cyc;
        bus_write(1'b1, A_DATA, 32'h155);
        wait_load(10, "single_load");
        check("single_latency", 32'(load_cyc), 32'(w + 2));
        bus_read(A_STATUS, rd);
        check("busy_during_frame", rd, status_word(0, 1, 1, 0, 0));
        wait_uart_idle(50);
        tick(2);
        bus_read(A_STATUS, rd);
        check("idle_after_frame", rd, status_word(0, 1, 0, 0, 0));

        // 3. overflow, ovf clear, ordered back-to-back frames
        bus_write(1'b1, A_CTRL, 32'h0);
        for (int i = 1; i <= 9; i++) bus_write(1'b1, A_DATA, 32'(i));
        bus_read(A_STATUS, rd);
        check("full_ovf_status", rd, status_word(1, 0, 0, ovf_m, DEPTH));
        bus_write(1'b1, A_STATUS, 32'h8);
        bus_read(A_STATUS, rd);
        check("ovf_cleared", rd, status_word(1, 0, 0, 0, DEPTH));
        frame_len = 10;
        start = load_count;
        bus_write(1'b1, A_CTRL, 32'h1);
        prev_load = 0;
        for (int i = 0; i < DEPTH; i++) begin
            wait_load(40, "burst_load");
            if (i > 0) check("burst_gap", 32'(load_cyc - prev_load), 32'(frame_len + 3));
            prev_load = load_cyc;
        end
        check("burst_count", 32'(load_count - start), 32'(DEPTH));
        wait_uart_idle(50);
        tick(20);
        bus_read(A_STATUS, rd);
        check("burst_done_status", rd, status_word(0, 1, 0, 0, 0));

        // 4. stale uart_wr_empty after reset
        hold_low = 1'b1;
        do_reset();
        bus_write(1'b1, A_CTRL, 32'h1);
        bus_write(1'b1, A_DATA, 32'($urandom_range(0, 255)));
        start = load_count;
        tick(20);
        check("hold_no_load", 32'(load_count - start), 32'h0);
        hold_low = 1'b0;
        w = cyc;
        wait_load(5, "hold_release_load");
        check("hold_release_latency", 32'(load_cyc), 32'(w + 1));
        wait_uart_idle(50);
        tick(2);

        // 5. flush mid-DRAIN
        bus_write(1'b1, A_CTRL, 32'h0);
        for (int i = 0; i < 5; i++) bus_write(1'b1, A_DATA, 32'($urandom_range(0, 255)));
        bus_write(1'b1, A_CTRL, 32'h1);
        wait_load(10, "flush_first_load");
        tick(3);
        bus_write(1'b1, A_CTRL, 32'h7);
        start = load_count;
        wait_uart_idle(50);
        tick(30);
        check("flush_no_load", 32'(load_count - start), 32'h0);
        bus_read(A_STATUS, rd);
        check("flush_status", rd, status_word(0, 1, 0, 0, 0));
        bus_read(A_CTRL, rd);
        check("flush_ctrl_read", rd, 32'h3);
        check("flush_irq", 32'(irq), 32'h1);

        // 6. reset during ARM
        bus_write(1'b1, A_CTRL, 32'h0);
        for (int i = 0; i < 4; i++) bus_write(1'b1, A_DATA, 32'(8'hA0 + i));
        bus_write(1'b1, A_CTRL, 32'h1);
        wait_load(10, "arm_reset_load");
        rst_n = 1'b0;
        tick(2);
        model_reset();
        rst_n = 1'b1;
        tick(1);
        bus_read(A_STATUS, rd);
        check("arm_reset_status", rd, 32'h2);
        check("arm_reset_wr_en", 32'(uart_wr_en), 32'h0);
        check("arm_reset_wr_data", uart_wr_data, 32'h0);
        check("arm_reset_irq", 32'(irq), 32'h0);
        bus_write(1'b1, A_CTRL, 32'h1);
        bus_write(1'b1, A_DATA, 32'h3C);
        wait_load(40, "post_reset_load");
        check("post_reset_uart_idle_before", 32'(ucnt), 32'(frame_len));
        wait_uart_idle(50);
        tick(3);

        // 7. randomized traffic against the reference queue
        do_reset();
        bus_write(1'b1, A_CTRL, 32'h1);
        for (int i = 0; i < 80; i++) begin
            if (uart_wr_empty && !uart_wr_en) frame_len = int'($urandom_range(2, 12));
            r = int'($urandom_range(0, 19));
            if (r == 0) bus_write(1'b1, A_CTRL, 32'h5);
            else        bus_write(1'b1, A_DATA, 32'($urandom_range(0, 255)));
            tick(int'($urandom_range(0, 4)));
        end
        begin
            bit drained;
            drained = 1'b0;
            for (int i = 0; i < 3000; i++) begin
                if (exp_q.size() == 0) begin
                    drained = 1'b1;
                    break;
                end
                tick(1);
            end
            checks++;
            if (!drained) begin
                errors++;
                $display("FAIL random_drain: %0d bytes still owed", exp_q.size());
            end
        end
        wait_uart_idle(50);
        tick(3);
        bus_read(A_STATUS, rd);
        check("random_final_status", rd, status_word(0, 1, 0, ovf_m, 0));
        bus_write(1'b1, A_STATUS, 32'h8);
        bus_read(A_STATUS, rd);
        check("random_ovf_clear", rd, 32'h2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
